fb_mem_arbiter: RTL

- Shares one Avalon-MM-style framebuffer memory port between two requesters: display scanout reads, which feed the pixel FIFO ahead of the VGA timing generator, and rasterizer pixel writes.
- Scanout has deadline priority when its FIFO signals urgency. Otherwise the requesters alternate round-robin, with a starvation bound on the rasterizer.
- Sits between the scanout/raster engines and the SDRAM/HPS bridge, in the memory clock domain.

---
 rtl/fb_arb_pkg.sv | 20 ++
 rtl/fb_rd_credit.sv | 41 ++++
 rtl/fb_mem_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/fb_arb_pkg.sv
// Shared types and default sizing for the framebuffer memory arbiter.
package fb_arb_pkg;

  typedef enum logic {OWN_SCAN, OWN_RAST} owner_t;

  localparam int unsigned FB_ADDR_W          = 26;
  localparam int unsigned FB_DATA_W          = 32;
  localparam int unsigned FB_BE_W            = FB_DATA_W / 8;
  localparam int unsigned FB_MAX_OUTSTANDING = 8;
  localparam int unsigned FB_STARVE_LIMIT    = 16;

  // One issued memory command; the avm_* outputs are driven straight from it.
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] wdata;
    logic [FB_BE_W-1:0]   be;
    logic                 is_read;
  } fb_cmd_t;

endpackage

// File: rtl/fb_rd_credit.sv
// Outstanding scanout read counter; read credit is available while below the limit.
module fb_rd_credit
  import fb_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = FB_MAX_OUTSTANDING,
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic             can_read,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && !dec && count_q < MaxCnt) begin
      count_d = count_q + CNT_W'(1);
    end else if (dec && !inc && count_q != '0) begin
      // Stray returns after a reset must not wrap the counter.
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign can_read = count_q < MaxCnt;
  assign count    = count_q;

endmodule

// File: rtl/fb_mem_arbiter.sv
// Arbitrates the framebuffer memory port between scanout reads and raster writes,
// with urgent-scanout priority, round-robin, and a raster starvation override.
module fb_mem_arbiter
  import fb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W          = FB_ADDR_W,
  parameter int unsigned DATA_W          = FB_DATA_W,
  parameter int unsigned MAX_OUTSTANDING = FB_MAX_OUTSTANDING,
  parameter int unsigned STARVE_LIMIT    = FB_STARVE_LIMIT
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               scan_valid,
  input  logic [ADDR_W-1:0]                  scan_addr,
  input  logic                               scan_urgent,
  output logic                               scan_ready,
  output logic [DATA_W-1:0]                  scan_rdata,
  output logic                               scan_rvalid,
  input  logic                               rast_valid,
  input  logic [ADDR_W-1:0]                  rast_addr,
  input  logic [DATA_W-1:0]                  rast_wdata,
  input  logic [DATA_W/8-1:0]                rast_be,
  output logic                               rast_ready,
  output logic [ADDR_W-1:0]                  avm_address,
  output logic                               avm_read,
  output logic                               avm_write,
  output logic [DATA_W-1:0]                  avm_writedata,
  output logic [DATA_W/8-1:0]                avm_byteenable,
  input  logic                               avm_waitrequest,
  input  logic [DATA_W-1:0]                  avm_readdata,
  input  logic                               avm_readdatavalid,
  output logic [$clog2(MAX_OUTSTANDING):0]   rd_outstanding
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIMIT);

  // The command struct is sized by the package, so the widths must agree.
  if (ADDR_W != FB_ADDR_W || DATA_W != FB_DATA_W) begin : g_width_check
    $error("fb_mem_arbiter: ADDR_W/DATA_W must match fb_arb_pkg command widths");
  end

  fb_cmd_t       cmd_q, cmd_d;
  logic          cmd_valid_q, cmd_valid_d;
  owner_t        last_q, last_d;
  logic [SW-1:0] starve_q, starve_d;

  logic can_read;
  logic slot_free;
  logic grant_scan, grant_rast;

  assign slot_free = ~cmd_valid_q | ~avm_waitrequest;

  always_comb begin
    grant_scan = 1'b0;
    grant_rast = 1'b0;
    if (reset_n && slot_free) begin
      if (scan_valid && scan_urgent && can_read) begin
        grant_scan = 1'b1;
      end else if (rast_valid && starve_q >= StarveMax) begin
        grant_rast = 1'b1;
      end else if (scan_valid && can_read && rast_valid) begin
        if (last_q == OWN_RAST) grant_scan = 1'b1;
        else                    grant_rast = 1'b1;
      end else if (scan_valid && can_read) begin
        grant_scan = 1'b1;
      end else if (rast_valid) begin
        grant_rast = 1'b1;
      end
    end
  end

  assign scan_ready = grant_scan;
  assign rast_ready = grant_rast;

  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    last_d      = last_q;
    starve_d    = starve_q;

    if (slot_free) begin
      cmd_valid_d = grant_scan | grant_rast;
      if (grant_scan) begin
        cmd_d.addr    = scan_addr;
        cmd_d.wdata   = '0;
        cmd_d.be      = '1;
        cmd_d.is_read = 1'b1;
        last_d        = OWN_SCAN;
      end else if (grant_rast) begin
        cmd_d.addr    = rast_addr;
        cmd_d.wdata   = rast_wdata;
        cmd_d.be      = rast_be;
        cmd_d.is_read = 1'b0;
        last_d        = OWN_RAST;
      end
    end

    if (!rast_valid || grant_rast) begin
      starve_d = '0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      last_q      <= OWN_RAST;
      starve_q    <= '0;
    end else begin
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      last_q      <= last_d;
      starve_q    <= starve_d;
    end
  end

  fb_rd_credit #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_rd_credit (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (grant_scan),
    .dec     (avm_readdatavalid),
    .can_read(can_read),
    .count   (rd_outstanding)
  );

  assign avm_address    = cmd_q.addr;
  assign avm_writedata  = cmd_q.wdata;
  assign avm_byteenable = cmd_q.be;
  assign avm_read       = cmd_valid_q & cmd_q.is_read;
  assign avm_write      = cmd_valid_q & ~cmd_q.is_read;

  // Read data is not owned by the arbiter; returns pass straight through in order.
  assign scan_rdata  = avm_readdata;
  assign scan_rvalid = avm_readdatavalid;

endmodule
